// File: rtl/zld_xc_pkg.sv
// Shared definitions for the zero run-length codec (encoder and decoder sides).
// Holds the default widths and the decoder FSM state encoding.
package zld_xc_pkg;

  localparam int ZLE_W  = 16;
  localparam int ZLE_CW = 4;
  localparam int ZLE_TAG = ZLE_W;

  typedef enum logic {
    ZLD_READ  = 1'b0,
    ZLD_ZEROS = 1'b1
  } zld_state_e;

endpackage

// File: rtl/zld_xc_fsm.sv
// Decoder control: tracks whether a zero run is being expanded, counts the
// zeros still owed, and generates the input busy and output load strobes.
module zld_xc_fsm
  import zld_xc_pkg::*;
#(
  parameter int CW = ZLE_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_v,
  input  logic          tag,
  input  logic [CW-1:0] cnt,
  input  logic          slot_free,
  output logic          i_b,
  output logic          load_lit,
  output logic          load_zero,
  output logic          state_
);

  zld_state_e    state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ZLD_READ;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    i_b       = reset || (state_q != ZLD_READ) || !slot_free;
    accept    = i_v && !i_b;
    state_d   = state_q;
    rem_d     = rem_q;
    load_lit  = 1'b0;
    load_zero = 1'b0;
    case (state_q)
      ZLD_READ: begin
        if (accept) begin
          if (!tag) begin
            load_lit = 1'b1;
          end else begin
            // The first zero goes out now; cnt more are still owed.
            load_zero = 1'b1;
            rem_d     = cnt;
            if (cnt != '0) state_d = ZLD_ZEROS;
          end
        end
      end
      ZLD_ZEROS: begin
        if (slot_free) begin
          load_zero = 1'b1;
          rem_d     = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = ZLD_READ;
        end
      end
      default: state_d = ZLD_READ;
    endcase
  end

  assign state_ = state_q;

endmodule

// File: rtl/zld_xc.sv
// Zero run-length decoder: literals pass through, run tokens expand into
// cnt+1 zero words. Owns the registered output word and the malformed-token flag.
module zld_xc
  import zld_xc_pkg::*;
#(
  parameter int W  = ZLE_W,
  parameter int CW = ZLE_CW
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_v,
  output logic         i_b,
  input  logic [W:0]   i_d,
  output logic         o_v,
  input  logic         o_b,
  output logic [W-1:0] o_d,
  output logic         err,
  output logic         state_
);

  // Stream handshake on both sides: a word moves on an edge where v=1 and b=0;
  // the producer holds v and data steady until that edge.
  logic slot_free;
  logic accept;
  logic malformed;
  logic load_lit;
  logic load_zero;

  assign slot_free = !o_v || !o_b;
  assign accept    = i_v && !i_b;
  assign malformed = i_d[W] && (i_d[W-1:CW] != '0);

  zld_xc_fsm #(.CW(CW)) u_fsm (
    .clock     (clock),
    .reset     (reset),
    .i_v       (i_v),
    .tag       (i_d[W]),
    .cnt       (i_d[CW-1:0]),
    .slot_free (slot_free),
    .i_b       (i_b),
    .load_lit  (load_lit),
    .load_zero (load_zero),
    .state_    (state_)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      o_v <= 1'b0;
      o_d <= '0;
      err <= 1'b0;
    end else begin
      err <= accept && malformed;
      if (load_lit) begin
        o_v <= 1'b1;
        o_d <= i_d[W-1:0];
      end else if (load_zero) begin
        o_v <= 1'b1;
        o_d <= '0;
      end else if (slot_free) begin
        o_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zld_xc.sv
// Bench for the zero run-length decoder: cycle-exact vector table, directed
// multi-cycle sequences, and a randomized encoder-to-decoder loopback.
module tb_zld_xc;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_v;
  logic        i_b;
  logic [16:0] i_d;
  logic        o_v;
  logic        o_b;
  logic [15:0] o_d;
  logic        err;
  logic        state_;

  zld_xc dut (
    .clock  (clock),
    .reset  (reset),
    .i_v    (i_v),
    .i_b    (i_b),
    .i_d    (i_d),
    .o_v    (o_v),
    .o_b    (o_b),
    .o_d    (o_d),
    .err    (err),
    .state_ (state_)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [16:0] tok_q[$];

  bit          rand_ob = 1'b0;
  bit          hold_v  = 1'b0;
  logic [15:0] hold_d  = '0;

  typedef struct {
    logic        iv;
    logic [16:0] id;
    logic        ob;
    logic        ov;
    logic [15:0] od;
    logic        ib;
    logic        er;
    logic        st;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // output monitor: records every transfer and checks stability under busy
  always @(negedge clock) begin
    if (!reset && hold_v) begin
      n_cmp++;
      if (!(o_v === 1'b1 && o_d === hold_d)) begin
        n_bad++;
        $display("FAIL hold_stable: got o_v=%0b o_d=%0h, expected o_v=1 o_d=%0h", o_v, o_d, hold_d);
      end
    end
    hold_v = !reset && o_v && o_b;
    hold_d = o_d;
    if (!reset && o_v && !o_b) got_q.push_back(o_d);
  end

  always @(posedge clock) begin
    #1;
    if (rand_ob) o_b = ($urandom_range(0, 2) == 0);
  end

  // driver tasks (all called at posedge+1)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [16:0] d, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    i_v   = 1'b1;
    i_d   = d;
    while (!acc && waits < 200) begin
      @(negedge clock);
      acc = !i_b;
      @(posedge clock);
      #1;
      if (!acc) waits++;
    end
    i_v = 1'b0;
    i_d = '0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0h not accepted, expected acceptance within 200 cycles", d);
    end
  endtask

  task automatic count_nonzero(input string name);
    int nz;
    nz = 0;
    foreach (got_q[k]) if (got_q[k] != 16'h0) nz++;
    check(name, nz, 0);
  endtask

  initial begin
    int w, w2, g, n_tok;

    vecs[0]  = '{1'b1, 17'h00005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 17'h00007, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 17'h00009, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 17'h10003, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 17'h000AA, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 17'h000AA, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 17'h000AA, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 17'h000AA, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 17'h10000, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 17'h01234, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 17'h10013, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 17'h00000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 17'h00000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 17'h00000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 17'h00000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 17'h00000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 17'h00000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 17'h00055, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 17'h00066, 1'b1, 1'b1, 16'h0055, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 17'h00066, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 17'h00000, 1'b0, 1'b1, 16'h0066, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 17'h00000, 1'b0, 1'b0, 16'h0066, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    i_v   = 1'b0;
    i_d   = '0;
    o_b   = 1'b0;
    step(3);
    @(negedge clock);
    check("reset i_b", i_b, 1);
    check("reset o_v", o_v, 0);
    check("reset o_d", o_d, 0);
    check("reset err", err, 0);
    check("reset state", state_, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // cycle-exact vector table
    for (int i = 0; i < 22; i++) begin
      i_v = vecs[i].iv;
      i_d = vecs[i].id;
      o_b = vecs[i].ob;
      @(negedge clock);
      check($sformatf("vec%0d o_v", i), o_v, vecs[i].ov);
      check($sformatf("vec%0d o_d", i), o_d, vecs[i].od);
      check($sformatf("vec%0d i_b", i), i_b, vecs[i].ib);
      check($sformatf("vec%0d err", i), err, vecs[i].er);
      check($sformatf("vec%0d state", i), state_, vecs[i].st);
      @(posedge clock);
      #1;
    end
    i_v = 1'b0;
    o_b = 1'b0;
    step(2);

    // single-zero run causes no stall, then a full 16-zero run
    got_q.delete();
    send_word(17'h10000, w);
    send_word(17'h000BB, w2);
    check("cnt0 no stall", w2, 0);
    step(3);
    check("cnt0 count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("cnt0 zero", got_q[0], 16'h0000);
      check("cnt0 next lit", got_q[1], 16'h00BB);
    end
    got_q.delete();
    send_word(17'h1000F, w);
    step(24);
    check("cnt15 count", got_q.size(), 16);
    count_nonzero("cnt15 nonzero");

    // backpressure in the middle of an 8-zero run
    got_q.delete();
    send_word(17'h10007, w);
    step(2);
    o_b = 1'b1;
    step(5);
    o_b = 1'b0;
    step(15);
    check("bp run count", got_q.size(), 8);
    count_nonzero("bp run nonzero");

    // reset in the middle of a 16-zero run
    got_q.delete();
    send_word(17'h1000F, w);
    g = 0;
    while (got_q.size() < 5 && g < 100) begin
      @(negedge clock);
      #1;
      g++;
    end
    check("reset-run reach 5", (g < 100), 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset-run o_v", o_v, 0);
    check("reset-run state", state_, 0);
    check("reset-run i_b", i_b, 0);
    step(20);
    check("reset-run zeros", got_q.size(), 5);
    send_word(17'h00001, w);
    step(3);
    check("reset-run after count", got_q.size(), 6);
    if (got_q.size() == 6) check("reset-run after lit", got_q[5], 16'h0001);

    // randomized loopback: reference encoder turns a plain stream into tokens
    got_q.delete();
    exp_q.delete();
    tok_q.delete();
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        int run;
        run = $urandom_range(1, 40);
        repeat (run) exp_q.push_back(16'h0000);
        while (run > 0) begin
          int chunk;
          chunk = (run > 16) ? 16 : run;
          tok_q.push_back({1'b1, 12'h000, 4'(chunk - 1)});
          run -= chunk;
        end
      end else begin
        logic [15:0] lit;
        lit = 16'($urandom_range(1, 65535));
        exp_q.push_back(lit);
        tok_q.push_back({1'b0, lit});
      end
    end
    n_tok   = tok_q.size();
    rand_ob = 1'b1;
    for (int k = 0; k < n_tok; k++) begin
      step($urandom_range(0, 2));
      send_word(tok_q[k], w);
    end
    g = 0;
    while (got_q.size() < exp_q.size() && g < 3000) begin
      step(1);
      g++;
    end
    rand_ob = 1'b0;
    step(1);
    o_b = 1'b0;
    step(5);
    check("loopback count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("loopback word%0d", k), got_q[k], exp_q[k]);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
